// File: rtl/shmem_pkg.sv
// Shared types, default geometry and one-hot helpers for the shared-memory
// subsystem (arbiter, clear sequencer, coordinate mapper).
package shmem_pkg;

   localparam int unsigned NO_BANKS_DEF       = 8;
   localparam int unsigned RAM_ADDR_WIDTH_DEF = 12;
   localparam int unsigned DATAW_DEF          = 8;

   // Helpers operate on a zero-extended vector so they serve any bank count up to this.
   localparam int unsigned MAX_BANKS = 32;
   localparam int unsigned IDXW      = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   function automatic logic onehot_valid(input logic [MAX_BANKS-1:0] v);
      return (v != '0) && ((v & (v - MAX_BANKS'(1))) == '0);
   endfunction

   function automatic logic [IDXW-1:0] onehot_to_index(input logic [MAX_BANKS-1:0] v);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_BANKS; i++) begin
         if (v[i]) begin
            idx = idx | i[IDXW-1:0];
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/shmem_clear_seq.sv
// Memory clear sequencer: walks every address and zeroes each bank as soon as
// the display read path leaves that bank free.
module shmem_clear_seq
   import shmem_pkg::*;
#(
   parameter int unsigned NO_BANKS       = NO_BANKS_DEF,
   parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_start,
   input  logic [NO_BANKS-1:0]       rd_block,
   output logic [NO_BANKS-1:0]       clr_we,
   output logic [RAM_ADDR_WIDTH-1:0] clr_addr,
   output logic                      clear_busy
);

   clr_state_e                state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic [NO_BANKS-1:0]       pend_q, pend_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      pend_d     = pend_q;
      clr_we     = '0;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
               pend_d     = '1;
            end
         end
         CLEAR: begin
            clr_we = pend_q & ~rd_block;
            // Banks still pending after this cycle are exactly the ones a read took.
            if ((pend_q & rd_block) == '0) begin
               pend_d = '1;
               if (clr_addr_q == '1) begin
                  state_d = IDLE;
               end else begin
                  clr_addr_d = clr_addr_q + RAM_ADDR_WIDTH'(1);
               end
            end else begin
               pend_d = pend_q & rd_block;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         clr_addr_q <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         pend_q     <= pend_d;
      end
   end

   assign clr_addr   = clr_addr_q;
   assign clear_busy = (state_q == CLEAR);

endmodule

// File: rtl/shmem_bank_arbiter.sv
// Per-bank port arbiter for the banked display RAM: display read > clear > writer,
// with a two-stage registered read return path.
module shmem_bank_arbiter
   import shmem_pkg::*;
#(
   parameter int unsigned NO_BANKS       = NO_BANKS_DEF,
   parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
   parameter int unsigned DATAW          = DATAW_DEF,
   parameter int unsigned BANKW          = $clog2(NO_BANKS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rd_en,
   input  logic [NO_BANKS-1:0]                rd_bank_select,
   input  logic [RAM_ADDR_WIDTH-1:0]          rd_address,
   output logic [DATAW-1:0]                   rd_data,
   output logic                               rd_data_valid,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [BANKW-1:0]                   wr_bank,
   input  logic [RAM_ADDR_WIDTH-1:0]          wr_address,
   input  logic [DATAW-1:0]                   wr_data,
   input  logic                               clear_start,
   output logic                               clear_busy,
   output logic [NO_BANKS-1:0]                bank_en,
   output logic [NO_BANKS-1:0]                bank_we,
   output logic [NO_BANKS*RAM_ADDR_WIDTH-1:0] bank_addr,
   output logic [NO_BANKS*DATAW-1:0]          bank_wdata,
   input  logic [NO_BANKS*DATAW-1:0]          bank_rdata
);

   logic [MAX_BANKS-1:0]      sel_ext;
   logic                      rd_hit;
   logic [NO_BANKS-1:0]       rd_take;
   logic [BANKW-1:0]          rd_idx;
   logic                      wr_bank_ok;
   logic                      wr_conflict;
   logic                      wr_fire;
   logic [NO_BANKS-1:0]       clr_we;
   logic [RAM_ADDR_WIDTH-1:0] clr_addr;

   logic                      p1_valid_q, p1_valid_d;
   logic                      p1_hit_q, p1_hit_d;
   logic [BANKW-1:0]          p1_idx_q, p1_idx_d;
   logic [DATAW-1:0]          rd_data_q, rd_data_d;
   logic                      rd_data_valid_q, rd_data_valid_d;

   assign sel_ext = MAX_BANKS'(rd_bank_select);
   assign rd_hit  = rd_en && onehot_valid(sel_ext);
   assign rd_take = rd_hit ? rd_bank_select : '0;
   assign rd_idx  = BANKW'(onehot_to_index(sel_ext));

   shmem_clear_seq #(
      .NO_BANKS       (NO_BANKS),
      .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
   ) u_clear_seq (
      .clk         (clk),
      .rst         (rst),
      .clear_start (clear_start),
      .rd_block    (rd_take),
      .clr_we      (clr_we),
      .clr_addr    (clr_addr),
      .clear_busy  (clear_busy)
   );

   always_comb begin
      wr_bank_ok  = (int'(wr_bank) < int'(NO_BANKS));
      wr_conflict = wr_bank_ok && rd_take[wr_bank];
      wr_ready    = !rst && !clear_busy && wr_bank_ok && !wr_conflict;
      wr_fire     = wr_valid && wr_ready;
   end

   // Bank ports are held idle while reset is asserted so an aborted clear stops immediately.
   always_comb begin
      bank_en    = '0;
      bank_we    = '0;
      bank_addr  = '0;
      bank_wdata = '0;
      if (!rst) begin
         for (int unsigned i = 0; i < NO_BANKS; i++) begin
            if (rd_take[i]) begin
               bank_en[i]                                   = 1'b1;
               bank_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] = rd_address;
            end else if (clr_we[i]) begin
               bank_en[i]                                   = 1'b1;
               bank_we[i]                                   = 1'b1;
               bank_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] = clr_addr;
            end else if (wr_fire && (wr_bank == BANKW'(i))) begin
               bank_en[i]                                   = 1'b1;
               bank_we[i]                                   = 1'b1;
               bank_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] = wr_address;
               bank_wdata[i*DATAW +: DATAW]                 = wr_data;
            end
         end
      end
   end

   always_comb begin
      p1_valid_d      = rd_en;
      p1_hit_d        = rd_hit;
      p1_idx_d        = rd_idx;
      rd_data_valid_d = p1_valid_q;
      rd_data_d       = '0;
      if (p1_hit_q) begin
         rd_data_d = bank_rdata[p1_idx_q*DATAW +: DATAW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_valid_q      <= 1'b0;
         p1_hit_q        <= 1'b0;
         p1_idx_q        <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
      end else begin
         p1_valid_q      <= p1_valid_d;
         p1_hit_q        <= p1_hit_d;
         p1_idx_q        <= p1_idx_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_shmem_bank_arbiter.sv
// Directed bench for shmem_bank_arbiter with a behavioural banked RAM and a
// read-return scoreboard.
module tb_shmem_bank_arbiter;

   localparam int NB = 8;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int DEPTH = 1 << AW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rd_en = 1'b0;
   logic [NB-1:0]     rd_bank_select = '0;
   logic [AW-1:0]     rd_address = '0;
   logic [DW-1:0]     rd_data;
   logic              rd_data_valid;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [2:0]        wr_bank = '0;
   logic [AW-1:0]     wr_address = '0;
   logic [DW-1:0]     wr_data = '0;
   logic              clear_start = 1'b0;
   logic              clear_busy;
   logic [NB-1:0]     bank_en;
   logic [NB-1:0]     bank_we;
   logic [NB*AW-1:0]  bank_addr;
   logic [NB*DW-1:0]  bank_wdata;
   logic [NB*DW-1:0]  bank_rdata;

   shmem_bank_arbiter #(
      .NO_BANKS       (NB),
      .RAM_ADDR_WIDTH (AW),
      .DATAW          (DW),
      .BANKW          (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rd_en          (rd_en),
      .rd_bank_select (rd_bank_select),
      .rd_address     (rd_address),
      .rd_data        (rd_data),
      .rd_data_valid  (rd_data_valid),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_bank        (wr_bank),
      .wr_address     (wr_address),
      .wr_data        (wr_data),
      .clear_start    (clear_start),
      .clear_busy     (clear_busy),
      .bank_en        (bank_en),
      .bank_we        (bank_we),
      .bank_addr      (bank_addr),
      .bank_wdata     (bank_wdata),
      .bank_rdata     (bank_rdata)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: synchronous read, one-cycle latency; fill_req loads a known pattern.
   logic [DW-1:0] mem [NB][DEPTH];
   logic          fill_req = 1'b0;

   function automatic logic [7:0] pat(input int b, input int a);
      if (b == 2 && a == 'h0A5) return 8'h3C;
      return 8'(((b * 37) + a) ^ 'hA5);
   endfunction

   always @(posedge clk) begin
      if (fill_req) begin
         for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
               mem[b][a] <= pat(b, a);
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (bank_en[b]) begin
               if (bank_we[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_wdata[b*DW +: DW];
               else            bank_rdata[b*DW +: DW] <= mem[b][bank_addr[b*AW +: AW]];
            end
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   typedef struct {
      int unsigned due;
      logic [7:0]  exp;
      bit          chk_data;
   } rd_exp_t;
   rd_exp_t sbq[$];
   bit      mon_on = 1'b0;

   task automatic push_rd(input logic [7:0] e, input bit c);
      sbq.push_back('{cyc + 2, e, c});
   endtask

   always @(negedge clk) begin : mon
      rd_exp_t e;
      if (mon_on) begin
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rd_valid", 64'(rd_data_valid), 64'(1));
            if (e.chk_data) chk("rd_data", 64'(rd_data), 64'(e.exp));
         end else begin
            chk("rd_idle", 64'(rd_data_valid), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rd_en = 1'b0;
      rd_bank_select = '0;
      rd_address = '0;
      wr_valid = 1'b0;
      clear_start = 1'b0;
   endtask

   task automatic fill();
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
   endtask

   function automatic int count_nonzero();
      int n = 0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < DEPTH; a++)
            if (mem[b][a] !== 8'h00) n++;
      return n;
   endfunction

   initial begin
      int busy_n;
      int wr_bad;
      int exp_n;
      int kk;
      int bad;

      fill();
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_rd_valid", 64'(rd_data_valid), 64'(0));
      chk("rst_busy", 64'(clear_busy), 64'(0));
      chk("rst_bank_en", 64'(bank_en), 64'(0));
      chk("rst_bank_we", 64'(bank_we), 64'(0));
      rst = 1'b0;
      mon_on = 1'b1;

      // single read, 2-cycle latency
      tick();
      rd_en = 1'b1; rd_bank_select = 8'b00000100; rd_address = 12'h0A5;
      push_rd(8'h3C, 1'b1);
      #1;
      chk("rd_bank_en", 64'(bank_en), 64'(8'b00000100));
      chk("rd_bank_we", 64'(bank_we), 64'(0));
      chk("rd_bank_addr", 64'(bank_addr[2*AW +: AW]), 64'(12'h0A5));
      tick();
      drive_idle();

      // write blocked by reads to the same bank for 5 cycles
      tick();
      wr_valid = 1'b1; wr_bank = 3'd3; wr_address = 12'h123; wr_data = 8'h5A;
      for (int k = 0; k < 5; k++) begin
         rd_en = 1'b1; rd_bank_select = 8'b00001000; rd_address = AW'(16 + k);
         push_rd(pat(3, 16 + k), 1'b1);
         #1;
         chk("wr_blocked", 64'(wr_ready), 64'(0));
         tick();
      end
      rd_en = 1'b0; rd_bank_select = '0;
      #1;
      chk("wr_accept", 64'(wr_ready), 64'(1));
      chk("wr_bank_en", 64'(bank_en), 64'(8'b00001000));
      chk("wr_bank_we", 64'(bank_we), 64'(8'b00001000));
      chk("wr_addr", 64'(bank_addr[3*AW +: AW]), 64'(12'h123));
      chk("wr_wdata", 64'(bank_wdata[3*DW +: DW]), 64'(8'h5A));
      tick();
      wr_valid = 1'b0;
      rd_en = 1'b1; rd_bank_select = 8'b00001000; rd_address = 12'h123;
      push_rd(8'h5A, 1'b1);
      tick();

      // read and write to different banks in the same cycle
      rd_en = 1'b1; rd_bank_select = 8'b00000010; rd_address = 12'h200;
      wr_valid = 1'b1; wr_bank = 3'd5; wr_address = 12'h321; wr_data = 8'hC3;
      push_rd(pat(1, 'h200), 1'b1);
      #1;
      chk("par_wr_ready", 64'(wr_ready), 64'(1));
      chk("par_bank_en", 64'(bank_en), 64'(8'b00100010));
      chk("par_bank_we", 64'(bank_we), 64'(8'b00100000));
      tick();
      wr_valid = 1'b0;
      rd_bank_select = 8'b00100000; rd_address = 12'h321;
      push_rd(8'hC3, 1'b1);
      tick();

      // non-one-hot selects return background pixel
      rd_en = 1'b1; rd_bank_select = 8'b00000000; rd_address = 12'h005;
      push_rd(8'h00, 1'b1);
      #1;
      chk("zero_sel_en", 64'(bank_en), 64'(0));
      tick();
      rd_bank_select = 8'b00000011;
      push_rd(8'h00, 1'b1);
      #1;
      chk("multi_sel_en", 64'(bank_en), 64'(0));
      tick();
      drive_idle();
      repeat (3) tick();

      // full clear without reads
      clear_start = 1'b1;
      #1;
      chk("clr_busy_pre", 64'(clear_busy), 64'(0));
      tick();
      clear_start = 1'b0;
      wr_valid = 1'b1; wr_bank = 3'd0; wr_address = 12'h007; wr_data = 8'hEE;
      busy_n = 0; wr_bad = 0;
      for (int k = 0; k < 10000; k++) begin
         if (!clear_busy) break;
         busy_n++;
         if (wr_ready) wr_bad++;
         tick();
      end
      wr_valid = 1'b0;
      chk("clr_duration", 64'(busy_n), 64'(4096));
      chk("clr_wr_ready", 64'(wr_bad), 64'(0));
      tick();
      chk("clr_mem_zero", 64'(count_nonzero()), 64'(0));
      rd_en = 1'b1; rd_bank_select = 8'b10000000; rd_address = 12'hFFF;
      push_rd(8'h00, 1'b1);
      tick();
      rd_bank_select = 8'b00000100; rd_address = 12'h0A5;
      push_rd(8'h00, 1'b1);
      tick();
      drive_idle();
      repeat (3) tick();

      // clear under display traffic on bank 0, odd cycles, with a redundant start
      fill();
      exp_n = 0;
      for (int a = 0; a < DEPTH; a++) exp_n += (exp_n % 2 == 1) ? 2 : 1;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busy_n = 0;
      kk = 0;
      while (kk < 20000) begin
         if (!clear_busy) break;
         busy_n++;
         rd_en = (kk % 2 == 1);
         rd_bank_select = 8'b00000001;
         rd_address = AW'(kk);
         if (rd_en) push_rd(8'h00, 1'b0);
         clear_start = (kk == 100);
         if (kk == 1) begin
            #1;
            chk("traffic_bank_we", 64'(bank_we), 64'(8'b11111110));
         end
         kk++;
         tick();
      end
      drive_idle();
      chk("traffic_duration", 64'(busy_n), 64'(exp_n));
      tick();
      chk("traffic_mem_zero", 64'(count_nonzero()), 64'(0));
      repeat (3) tick();

      // reset at clr_addr 2000 aborts the clear
      fill();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busy_n = 0;
      for (int k = 0; k < 2000; k++) begin
         if (clear_busy) busy_n++;
         tick();
      end
      chk("abort_busy_count", 64'(busy_n), 64'(2000));
      chk("abort_busy_before", 64'(clear_busy), 64'(1));
      rst = 1'b1;
      #1;
      chk("abort_bank_en_in_rst", 64'(bank_en), 64'(0));
      tick();
      chk("abort_busy", 64'(clear_busy), 64'(0));
      chk("abort_bank_en", 64'(bank_en), 64'(0));
      chk("abort_bank_we", 64'(bank_we), 64'(0));
      chk("abort_rd_data", 64'(rd_data), 64'(0));
      chk("abort_rd_valid", 64'(rd_data_valid), 64'(0));
      rst = 1'b0;
      tick();
      bad = 0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < DEPTH; a++)
            if (mem[b][a] !== ((a < 2000) ? 8'h00 : pat(b, a))) bad++;
      chk("abort_partial_mem", 64'(bad), 64'(0));

      for (int k = 0; k < 10; k++) begin
         if (sbq.size() == 0) break;
         tick();
      end
      chk("sb_drained", 64'(sbq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shmem_bank_arbiter.md
# shmem_bank_arbiter

Owns the physical ports of the banked display RAM in the shared-memory subsystem. It arbitrates each bank's single port between three users: the display read path (bank one-hot plus address from the coordinate mapper), the spectrum writer (valid/ready), and an internal clear sequencer that zeroes the whole memory on request. Display reads always win, because pixel timing cannot stall; the writer and the clear sequencer use the cycles the display leaves free.

## Interface
Parameters:
- NO_BANKS, 8, number of RAM banks (one-hot select width)
- RAM_ADDR_WIDTH, 12, address width per bank
- DATAW, 8, data word width
- BANKW, $clog2(NO_BANKS), binary bank index width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  display read request this cycle
- rd_bank_select  in  NO_BANKS  one-hot bank select from the coordinate mapper
- rd_address  in  RAM_ADDR_WIDTH  read address
- rd_data  out  DATAW  pixel data, registered
- rd_data_valid  out  1  rd_data corresponds to the rd_en two cycles earlier
- wr_valid  in  1  writer has a word
- wr_ready  out  1  word accepted this cycle when wr_valid && wr_ready
- wr_bank  in  BANKW  binary target bank
- wr_address  in  RAM_ADDR_WIDTH  target address
- wr_data  in  DATAW  write data
- clear_start  in  1  one-cycle pulse; starts the memory clear
- clear_busy  out  1  clear in progress
- bank_en  out  NO_BANKS  per-bank port enable
- bank_we  out  NO_BANKS  per-bank write enable
- bank_addr  out  NO_BANKS*RAM_ADDR_WIDTH  per-bank address; bank i occupies slice i
- bank_wdata  out  NO_BANKS*DATAW  per-bank write data
- bank_rdata  in  NO_BANKS*DATAW  per-bank read data; synchronous read, 1-cycle latency

## Operation
- Per-bank priority, evaluated every cycle: display read > clear > writer.
- Display read:
  - A read is valid only when rd_en=1 and rd_bank_select is exactly one-hot.
  - For a valid read, set bank_en=1 and bank_we=0 on the selected bank, with bank_addr=rd_address.
  - If rd_bank_select is zero or multi-hot, enable no bank. The pipeline still returns rd_data=0 with rd_data_valid=1 (background pixel).
- Writer:
  - wr_ready = !clear_busy && !(valid read && rd_bank_select[wr_bank]).
  - wr_ready is combinational from wr_bank and the read inputs, not from wr_valid.
  - On accept, set bank_en=1 and bank_we=1 on wr_bank in the same cycle, with the address and data.
  - wr_bank >= NO_BANKS: wr_ready=0 permanently for that word; the writer must not present it.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start. This loads clr_addr=0 and pend_mask=all ones, and sets clear_busy=1.
  - Each cycle in CLEAR, write 0 at clr_addr to every bank with pend_mask[i]=1 that is not taken by a valid read, then clear those mask bits.
  - When the mask would become all zero, increment clr_addr and reload pend_mask to all ones. A single cycle can both finish and advance.
  - After the write of address 2^RAM_ADDR_WIDTH-1 completes in all banks: CLEAR -> IDLE, clear_busy=0 on the next cycle.
  - clear_start while in CLEAR is ignored; the clear does not restart.
- Reset: state=IDLE and all pipeline registers cleared.
  - Reset values: rd_data=0, rd_data_valid=0, clear_busy=0, bank_en=0, bank_we=0.
  - A reset during CLEAR aborts the clear; memory contents are left partially cleared.

## Timing
- Read latency is 2 cycles.
  - Cycle N: rd_en and the bank ports are driven.
  - Cycle N+1: bank_rdata is valid, and the registered bank index and valid flag are used to mux it.
  - Cycle N+2: rd_data and rd_data_valid are registered outputs.
  - Back-to-back reads run at full rate.
- Writes complete in the accept cycle; there is no output response.
- A write accepted in cycle N to address A is visible to a read of A issued at N+1.
- Read and write to the same bank in the same cycle: the read wins and wr_ready=0. The writer holds its word; no data is lost.
- Minimum clear duration is 2^RAM_ADDR_WIDTH cycles, extended by one cycle per address whose bank set is blocked by reads.
- All bank_* outputs are combinational from the current inputs and state. The RAM registers them.

## Structure
- Shared package shmem_pkg:
  - clear state enum {IDLE, CLEAR}
  - function onehot_valid(NO_BANKS vector)
  - function onehot_to_index
  - The same default parameter constants are reused by the coordinate mapper.
- Sub-module shmem_clear_seq contains the FSM, clr_addr, pend_mask and clear_busy. It takes a per-bank "blocked by read" vector and returns per-bank clear write enables.
- The arbiter top holds the priority logic, the read pipeline and the output mux.

## Test plan
- Reset, then a single read: rd_en=1, rd_bank_select=8'b00000100, rd_address=12'h0A5 with bank 2 holding 8'h3C there -> rd_data=8'h3C with rd_data_valid=1 exactly 2 cycles later.
- Write conflict: wr_valid=1, wr_bank=3 while reads continuously target 8'b00001000 for 5 cycles -> wr_ready=0 for those 5 cycles. The write is accepted in the first cycle after the reads stop; a read back returns the written data.
- Non-one-hot select: rd_bank_select=8'b00000000, then 8'b00000011 -> no bank_en asserted, rd_data=0 with rd_data_valid=1.
- Full clear with no reads: clear_start pulse -> clear_busy=1 for exactly 4096 cycles, and every bank/address reads 0 afterwards. wr_ready=0 throughout.
- Clear under display traffic: bank 0 is read every other cycle -> clear completes in 4096 + (blocked addresses) cycles, and every location reads 0. A clear_start mid-clear has no effect.
- Reset mid-clear: assert rst at clr_addr≈2000 -> clear_busy=0 and all outputs 0 the next cycle. Addresses ≥2000 keep their pre-clear data.
